// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-load, LSB-first serial frame transmitter.
// Idle line level is 1. Optional 0,1,0,1 start preamble is compiled in when
// the macro SERIAL_FRAME_TX_PREAMBLE_EN is defined; otherwise frames carry
// payload bits only.
//
// state | meaning
// IDLE  | line idles at 1, waiting for load
// PRE   | emitting the 4-bit 0,1,0,1 preamble (preamble builds only)
// DATA  | emitting payload bits LSB-first, one per clock
`timescale 1ns/1ps

module serial_frame_tx #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
        PRE  = 3'b010,
`endif
        DATA = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               sout_q, sout_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               accept;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
    logic [1:0]         pre_cnt_q, pre_cnt_d;
`endif

    // Ready while idle, or during the last payload bit so frames can chain.
    assign ready  = (state_q == IDLE) || ((state_q == DATA) && (cnt_q == CNT_LAST));
    assign accept = load && ready;

    // Next-state, counter and shift-register update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
        pre_cnt_d = pre_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = data;
                    cnt_d   = '0;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
                    state_d   = PRE;
                    pre_cnt_d = 2'd0;
`else
                    state_d   = DATA;
`endif
                end
            end
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
            PRE: begin
                if (pre_cnt_q == 2'd3) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + 2'd1;
                end
            end
`endif
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    if (accept) begin
                        // Back-to-back: next frame starts with no idle gap.
                        shreg_d = data;
                        cnt_d   = '0;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
                        state_d   = PRE;
                        pre_cnt_d = 2'd0;
`else
                        state_d   = DATA;
`endif
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shreg_d = shreg_q >> 1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output registers are loaded from the next-state view, so the bit that
    // will be current after this edge is what appears on the line.
    always_comb begin
        sout_d  = 1'b1;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
            PRE: begin
                sout_d  = pre_cnt_d[0];
                valid_d = 1'b1;
            end
`endif
            DATA: begin
                sout_d  = shreg_d[0];
                valid_d = 1'b1;
                done_d  = (cnt_d == CNT_LAST);
            end
            default: begin
                sout_d  = 1'b1;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            sout_q    <= 1'b1;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
            pre_cnt_q <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            sout_q    <= sout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
            pre_cnt_q <= pre_cnt_d;
`endif
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign busy       = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx. Driver acts on negedge; expected line bits
// are queued per accepted load and a monitor checks them after each posedge.
`timescale 1ns/1ps

module tb_serial_frame_tx;

    localparam int W = 21;
`ifdef SERIAL_FRAME_TX_PREAMBLE_EN
    localparam int PRE_LEN = 4;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam int FRAME = W + PRE_LEN;

    // 21'h0D54A on the line in time order (hand-derived, LSB first).
    localparam logic [0:20] HAND_SEQ = 21'b010100101010101100000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data;
    logic         load;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         busy;
    logic         done;

    typedef struct {
        logic sout;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    serial_frame_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d, input bit use_hand);
        exp_t e;
        for (int i = 0; i < PRE_LEN; i++) begin
            e.sout = (i % 2 == 1);
            e.done = 1'b0;
            sb_q.push_back(e);
        end
        for (int i = 0; i < W; i++) begin
            e.sout = use_hand ? HAND_SEQ[i] : d[i];
            e.done = (i == W - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_drain_left"}, sb_q.size(), 0);
    endtask

    // Monitor: compare line outputs against the scoreboard after every edge.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sout", sout, e.sout);
                chk("done", done, e.done);
                chk("sout_valid", sout_valid, 1);
                chk("busy", busy, 1);
            end else begin
                chk("idle_sout", sout, 1);
                chk("idle_valid", sout_valid, 0);
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
            end
        end
    end

    initial begin
        // Reset held 3 clocks with load asserted: nothing may start.
        rst  = 1'b1;
        load = 1'b1;
        data = 21'h0D54A;
        @(negedge clk);
        mon_en = 1'b1;
        tick(2);
        chk("ready_after_reset", ready, 1);
        rst  = 1'b0;
        load = 1'b0;
        tick(3);

        // Single frame, hand-derived sequence.
        data = 21'h0D54A;
        load = 1'b1;
        push_frame(21'h0D54A, 1'b1);
        tick(1);
        load = 1'b0;
        data = 21'h1A2B3;
        chk("ready_midframe", ready, 0);
        drain("single");
        tick(1);
        chk("ready_idle", ready, 1);
        tick(2);

        // Back-to-back: all ones then all zeros, no gap.
        data = 21'h1FFFFF;
        load = 1'b1;
        push_frame(21'h1FFFFF, 1'b0);
        tick(1);
        load = 1'b0;
        tick(FRAME - 1);
        chk("ready_lastbit", ready, 1);
        data = 21'h000000;
        load = 1'b1;
        push_frame(21'h000000, 1'b0);
        tick(1);
        load = 1'b0;
        chk("ready_b2b_start", ready, 0);
        drain("b2b");
        tick(2);

        // Load while busy is ignored; data changes have no effect.
        data = 21'h0F0F3;
        load = 1'b1;
        push_frame(21'h0F0F3, 1'b0);
        tick(1);
        load = 1'b0;
        tick(4);
        data = 21'h155555;
        load = 1'b1;
        chk("ready_busy", ready, 0);
        tick(1);
        load = 1'b0;
        data = 21'h0;
        drain("busy_load");
        tick(2);

        // Reset mid-frame aborts; a fresh load afterwards sends a full frame.
        data = 21'h12345;
        load = 1'b1;
        push_frame(21'h12345, 1'b0);
        tick(1);
        load = 1'b0;
        tick(9);
        rst = 1'b1;
        sb_q.delete();
        tick(1);
        rst = 1'b0;
        chk("ready_after_abort", ready, 1);
        tick(1);
        data = 21'h0A5A5;
        load = 1'b1;
        push_frame(21'h0A5A5, 1'b0);
        tick(1);
        load = 1'b0;
        drain("after_abort");
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel `WIDTH`-bit word through a ready/load handshake and shifts it out LSB-first on a one-bit line, one bit per clock. It is the sending end of the serial bit-stream path whose receiving end is the `0101` sequence-detector FSM. The optional preamble is that same pattern, so a downstream detector marks each frame start. The idle line level is 1, which holds the detector in its reset state.

## Interface
- `WIDTH`, default 21: payload bits per frame; legal range ≥ 2.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset: synchronous, active-high.
- `data`  in  `WIDTH`  payload word; sampled only on an accepted load.
- `load`  in  1  request to send `data`; accepted when `load && ready` at a posedge.
- `ready`  out  1  block can accept a load this cycle; combinational from state/counter.
- `sout`  out  1  serial line, registered; idles at 1.
- `sout_valid`  out  1  registered; high while `sout` carries a preamble or payload bit.
- `busy`  out  1  registered; high from the cycle after acceptance through the last payload bit.
- `done`  out  1  registered one-cycle pulse, coincident with the last payload bit on `sout`.

## Operation
- States: IDLE, PRE, DATA. One-hot encoding. Illegal encodings recover to IDLE on the next clock.
- Reset values: state IDLE, `sout`=1, `sout_valid`=0, `busy`=0, `done`=0, bit counter 0, shift register 0. `ready`=1 after reset.
- IDLE: `sout`=1, `sout_valid`=0.
  - On accept, capture `data` into the shift register.
  - Go to PRE if the preamble is compiled in, else go to DATA.
- PRE: 4 cycles emitting 0, 1, 0, 1 in time order, then DATA. The shift register is untouched.
- DATA: `WIDTH` cycles emitting shift register bit 0, then shifting right by 1.
  - Counter runs 0..`WIDTH`-1 and is sized `$clog2(WIDTH)`. It clears on entry to PRE or DATA.
- `ready` = (state==IDLE) or (state==DATA and counter==`WIDTH`-1).
  - Back-to-back: a load accepted during the last payload bit starts the next frame on the following cycle, with no idle gap.
  - The counter reloads to 0 and the new word is captured.
- Without a back-to-back load, the block returns to IDLE after the last bit: `sout`=1, `sout_valid`=0, `busy`=0.
- `load` while `ready`=0 is ignored, with no queuing. Changes on `data` outside acceptance have no effect.
- `rst` mid-frame aborts the frame. All outputs return to their reset values on that edge, with no partial-frame `done`.
- `done` is never high outside a DATA last-bit cycle.

## Timing
- Accept at posedge T: the first bit appears on `sout` in cycle T+1, so latency is 1 clock.
- With preamble:
  - Preamble occupies cycles T+1..T+4.
  - Payload bit i appears at T+5+i.
  - `done` is high at T+4+`WIDTH`.
  - Frame length is `WIDTH`+4 cycles.
- Without preamble:
  - Payload bit i appears at T+1+i.
  - `done` is high at T+`WIDTH`.
  - Frame length is `WIDTH` cycles.
- `sout_valid` is high exactly for the frame length.
  - It stays continuously high across back-to-back frames.
  - It drops for at least 1 cycle only when no load arrives in the last-bit cycle.
- `busy` has the same waveform as `sout_valid`.

## Configuration
- `SERIAL_FRAME_TX_PREAMBLE_EN` defined: the PRE state and the 4-bit 0,1,0,1 preamble are compiled in. Frames are `WIDTH`+4 bits.
- Undefined: the PRE state is removed from the RTL, accept goes straight to DATA, and frames are `WIDTH` bits.
- The handshake, reset values and `done` rules are identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 3 clocks with `load`=1 -> `sout`=1, `sout_valid`=0, `busy`=0, `done`=0, `ready`=1, and no frame starts.
- Single frame, macro undefined, `WIDTH`=21, `data`=21'h0D54A:
  - `sout` over T+1..T+21 reads 0,1,0,1,0,0,1,0,1,0,1,0,1,0,1,1,0,0,0,0,0.
  - `done` is high only at T+21; `sout`=1 and `ready`=1 at T+22.
- Single frame, macro defined, same data:
  - `sout` reads 0,1,0,1 at T+1..T+4, then the sequence above at T+5..T+25.
  - `done` is high at T+25.
  - A `0101` detector driven by `sout` fires at T+4.
- Back-to-back: load 21'h1FFFFF, then load 21'h000000 in its last-bit cycle -> 21 ones, then 21 zeros contiguous, `sout_valid` never drops, `done` pulses twice, 21 cycles apart (macro undefined).
- Load while busy: pulse `load` with 21'h155555 at T+5 of an active frame -> ignored; the original payload completes unchanged.
- Reset mid-frame: assert `rst` at T+10 -> at T+11 all outputs equal reset values and `done` never pulses. A new load at T+12 produces a clean full frame.
